// File: rtl/scan_unload_ctl.sv
// scan_unload_ctl: unloads an attached mux-scan chain into parallel words.
// A START request runs one CAPTURE cycle (the chain loads its D0 data),
// then CHAIN_LEN shift cycles that pack SO into WORD_W-bit words. The
// words are handed out on a DVALID/DREADY handshake. Shifting stalls
// whenever a completed word has nowhere to go.
// Optional feature: define SCAN_UNLOAD_RESTORE_EN to loop SO back into SI
// during SHIFT. The chain then ends an unload holding its captured data.
module scan_unload_ctl #(
   parameter int unsigned CHAIN_LEN = 16,
   parameter int unsigned WORD_W    = 8
) (
   input  logic              CK,
   input  logic              GSR,
   input  logic              START,
   input  logic              SO,
   output logic              SD,
   output logic              SP,
   output logic              SI,
   output logic [WORD_W-1:0] DOUT,
   output logic              DVALID,
   input  logic              DREADY,
   output logic              BUSY,
   output logic              DONE
);

   localparam int unsigned CntW = $clog2(CHAIN_LEN + 1);
   localparam int unsigned AccW = $clog2(WORD_W + 1);

   typedef enum logic [1:0] {StIdle, StCapture, StShift, StFlush} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [AccW-1:0]   acc_cnt_q, acc_cnt_d;
   logic [WORD_W-1:0] acc_q, acc_d;
   logic [WORD_W-1:0] dout_q, dout_d;
   logic              dvalid_q, dvalid_d;
   logic              done_q, done_d;

   logic              last_bit;
   logic              word_full;
   logic              word_end;
   logic              stall;
   logic              shift_en;
   logic [WORD_W-1:0] acc_next;

   // Decode of the current shift cycle
   always_comb begin
      last_bit  = (bit_cnt_q == CntW'(CHAIN_LEN - 1));
      word_full = (acc_cnt_q == AccW'(WORD_W - 1));
      word_end  = last_bit | word_full;
      // A word-completing shift must not overwrite an unaccepted word
      stall     = (state_q == StShift) & word_end & dvalid_q & ~DREADY;
      shift_en  = (state_q == StShift) & ~stall;
      // Upper accumulator bits are always zero, so OR-ing in is enough
      acc_next  = acc_q | (WORD_W'(SO) << acc_cnt_q);
   end

   // State register
   always_ff @(posedge CK or negedge GSR) begin
      if (!GSR) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (START) state_d = StCapture;
         StCapture: state_d = StShift;
         StShift:   if (shift_en && last_bit) state_d = StFlush;
         // The final word was loaded on the last shift edge
         StFlush:   state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Chain control and status outputs
   always_comb begin
      SD   = (state_q == StShift);
      SP   = (state_q == StCapture) | shift_en;
      BUSY = (state_q != StIdle);
`ifdef SCAN_UNLOAD_RESTORE_EN
      SI   = (state_q == StShift) ? SO : 1'b0;
`else
      SI   = 1'b0;
`endif
      DOUT   = dout_q;
      DVALID = dvalid_q;
      DONE   = done_q;
   end

   // Datapath registers: counters, accumulator, output word
   always_ff @(posedge CK or negedge GSR) begin
      if (!GSR) begin
         bit_cnt_q <= '0;
         acc_cnt_q <= '0;
         acc_q     <= '0;
         dout_q    <= '0;
         dvalid_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         acc_cnt_q <= acc_cnt_d;
         acc_q     <= acc_d;
         dout_q    <= dout_d;
         dvalid_q  <= dvalid_d;
         done_q    <= done_d;
      end
   end

   // Datapath next state: sampling, word hand-off, handshake
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      acc_cnt_d = acc_cnt_q;
      acc_d     = acc_q;
      dout_d    = dout_q;
      dvalid_d  = dvalid_q;
      // DONE is high in the IDLE cycle that follows FLUSH
      done_d    = (state_q == StFlush);

      if (dvalid_q && DREADY) begin
         dvalid_d = 1'b0;
      end

      if (state_q == StCapture) begin
         bit_cnt_d = '0;
         acc_cnt_d = '0;
         acc_d     = '0;
      end

      if (shift_en) begin
         bit_cnt_d = bit_cnt_q + CntW'(1);
         if (word_end) begin
            // A load takes priority over a same-edge accept, so no bubble
            dout_d    = acc_next;
            dvalid_d  = 1'b1;
            acc_d     = '0;
            acc_cnt_d = '0;
         end else begin
            acc_d     = acc_next;
            acc_cnt_d = acc_cnt_q + AccW'(1);
         end
      end
   end

endmodule
